// File: rtl/riio_gpo_tx_ctrl.sv
// riio_gpo_tx_ctrl
// Transmit-side controller for a bidirectional pad. A parallel word taken over
// a valid/ready handshake is serialized onto DO_O with OE_O asserted. Each bit
// is held for DIV clocks, and TURN_CYC clocks of idle level are driven with
// OE_O high before the first bit and after the last, so the pad never drives
// an undefined level.
//
// Handshake: a word is accepted on a rising edge where VALID_I and READY_O
// are both high. READY_O is high only in IDLE. VALID_I, DATA_I and
// MSB_FIRST_I are ignored while BUSY_O is high. Nothing is queued.
//
// DBG_STATE_O exposes the FSM state so external checkers can observe it.
module riio_gpo_tx_ctrl #(
  parameter int WIDTH    = 8,
  parameter int DIV      = 4,
  parameter int TURN_CYC = 2
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             VALID_I,
  output logic             READY_O,
  input  logic [WIDTH-1:0] DATA_I,
  input  logic             MSB_FIRST_I,
  input  logic             IDLE_LVL_I,
  input  logic             ABORT_I,
  output logic             DO_O,
  output logic             OE_O,
  output logic             BUSY_O,
  output logic             DONE_O,
  output logic             ABRT_O,
  output logic [1:0]       DBG_STATE_O
);

  // Counter widths. The turn counter needs at least one bit even when
  // TURN_CYC is 0; in that case it is never used.
  localparam int BCW = $clog2(WIDTH + 1);
  localparam int DCW = $clog2(DIV + 1);
  localparam int TCW = (TURN_CYC > 0) ? $clog2(TURN_CYC + 1) : 1;

  // Terminal counts. Each counter runs from 0 up to its terminal value and
  // never wraps inside a word.
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(WIDTH - 1);
  localparam logic [DCW-1:0] DIV_LAST  = DCW'(DIV - 1);
  localparam logic [TCW-1:0] TURN_LAST = TCW'(TURN_CYC - 1);

  // FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  logic [1:0]       state_q,     state_d;
  logic [BCW-1:0]   bit_cnt_q,   bit_cnt_d;
  logic [DCW-1:0]   div_cnt_q,   div_cnt_d;
  logic [TCW-1:0]   turn_cnt_q,  turn_cnt_d;
  logic [WIDTH-1:0] sh_q,        sh_d;
  logic             lvl_q,       lvl_d;
  logic             abrt_pend_q, abrt_pend_d;
  logic             do_q,        do_d;
  logic             oe_q,        oe_d;
  logic             ready_q,     ready_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;
  logic             abrt_q,      abrt_d;

  // Word reordered so the first bit to send always sits in the MSB; the
  // shifter then only ever drives sh_q[WIDTH-1] and shifts left.
  logic [WIDTH-1:0] data_rev;
  logic [WIDTH-1:0] data_ord;

  // Bit-reverse DATA_I and select the transmit order sampled at accept
  always_comb begin
    data_rev = '0;
    for (int i = 0; i < WIDTH; i++) begin
      data_rev[i] = DATA_I[WIDTH-1-i];
    end
    data_ord = MSB_FIRST_I ? DATA_I : data_rev;
  end

  // Control flags raised inside the state case and applied afterwards
  logic go_hold;
  logic finish;
  logic fin_abrt;

  // Next-state, counter and registered-output logic
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    div_cnt_d   = div_cnt_q;
    turn_cnt_d  = turn_cnt_q;
    sh_d        = sh_q;
    lvl_d       = lvl_q;
    abrt_pend_d = abrt_pend_q;
    do_d        = do_q;
    oe_d        = oe_q;
    ready_d     = ready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    abrt_d      = abrt_q;
    go_hold     = 1'b0;
    finish      = 1'b0;
    fin_abrt    = abrt_pend_q;

    case (state_q)
      ST_IDLE: begin
        // Idle: pad released, DO tracks the idle level one clock late.
        ready_d = 1'b1;
        busy_d  = 1'b0;
        oe_d    = 1'b0;
        do_d    = IDLE_LVL_I;
        if (VALID_I && ready_q) begin
          sh_d        = data_ord;
          lvl_d       = IDLE_LVL_I;
          abrt_pend_d = 1'b0;
          ready_d     = 1'b0;
          busy_d      = 1'b1;
          oe_d        = 1'b1;
          bit_cnt_d   = '0;
          div_cnt_d   = '0;
          turn_cnt_d  = '0;
          if (TURN_CYC == 0) begin
            state_d = ST_SHIFT;
            do_d    = data_ord[WIDTH-1];
          end else begin
            state_d = ST_SETUP;
            do_d    = IDLE_LVL_I;
          end
        end
      end

      ST_SETUP: begin
        // Setup turnaround: OE high at the idle level before the first bit.
        if (ABORT_I) begin
          abrt_pend_d = 1'b1;
          go_hold     = 1'b1;
        end else if (turn_cnt_q == TURN_LAST) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          do_d      = sh_q[WIDTH-1];
        end else begin
          turn_cnt_d = turn_cnt_q + 1'b1;
        end
      end

      ST_SHIFT: begin
        // Data phase: each bit stays on DO for DIV clocks.
        if (ABORT_I) begin
          abrt_pend_d = 1'b1;
          if (TURN_CYC == 0) begin
            finish   = 1'b1;
            fin_abrt = 1'b1;
          end else begin
            go_hold = 1'b1;
          end
        end else if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
            if (TURN_CYC == 0) begin
              finish = 1'b1;
            end else begin
              go_hold = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            sh_d      = sh_q << 1;
            do_d      = sh_d[WIDTH-1];
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end

      ST_HOLD: begin
        // Hold turnaround: OE high at the idle level after the data.
        // Abort is ignored here; the word is already ending.
        if (turn_cnt_q == TURN_LAST) begin
          finish = 1'b1;
        end else begin
          turn_cnt_d = turn_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (go_hold) begin
      state_d    = ST_HOLD;
      turn_cnt_d = '0;
      do_d       = lvl_q;
    end

    // Word completion: release the pad and pulse DONE together with READY.
    if (finish) begin
      state_d = ST_IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      ready_d = 1'b1;
      done_d  = 1'b1;
      abrt_d  = fin_abrt;
      do_d    = IDLE_LVL_I;
    end
  end

  // State and output registers; reset drops OE immediately
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      div_cnt_q   <= '0;
      turn_cnt_q  <= '0;
      sh_q        <= '0;
      lvl_q       <= 1'b0;
      abrt_pend_q <= 1'b0;
      do_q        <= 1'b0;
      oe_q        <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      abrt_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      div_cnt_q   <= div_cnt_d;
      turn_cnt_q  <= turn_cnt_d;
      sh_q        <= sh_d;
      lvl_q       <= lvl_d;
      abrt_pend_q <= abrt_pend_d;
      do_q        <= do_d;
      oe_q        <= oe_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      abrt_q      <= abrt_d;
    end
  end

  assign DO_O        = do_q;
  assign OE_O        = oe_q;
  assign READY_O     = ready_q;
  assign BUSY_O      = busy_q;
  assign DONE_O      = done_q;
  assign ABRT_O      = abrt_q;
  assign DBG_STATE_O = state_q;

endmodule

// File: tb/tb_riio_gpo_tx_ctrl.sv
// Bench for riio_gpo_tx_ctrl: default-parameter instance checked cycle by
// cycle against an expected queue, plus a WIDTH=1/DIV=1/TURN_CYC=0 instance.
module tb_riio_gpo_tx_ctrl;

  localparam int W = 8;
  localparam int D = 4;
  localparam int T = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- main DUT ----------------
  logic         valid = 1'b0;
  logic [W-1:0] data  = '0;
  logic         msb   = 1'b1;
  logic         lvl   = 1'b0;
  logic         abort = 1'b0;
  logic         ready, do_o, oe, busy, done, abrt;
  logic [1:0]   dbg_state;

  riio_gpo_tx_ctrl #(.WIDTH(W), .DIV(D), .TURN_CYC(T)) u_dut (
    .CLK_I(clk), .RST_I(rst), .VALID_I(valid), .READY_O(ready),
    .DATA_I(data), .MSB_FIRST_I(msb), .IDLE_LVL_I(lvl), .ABORT_I(abort),
    .DO_O(do_o), .OE_O(oe), .BUSY_O(busy), .DONE_O(done), .ABRT_O(abrt),
    .DBG_STATE_O(dbg_state)
  );

  // ---------------- corner DUT ----------------
  logic       c_valid = 1'b0;
  logic [0:0] c_data  = '0;
  logic       c_ready, c_do, c_oe, c_busy, c_done, c_abrt;
  logic [1:0] c_dbg_state;

  riio_gpo_tx_ctrl #(.WIDTH(1), .DIV(1), .TURN_CYC(0)) u_corner (
    .CLK_I(clk), .RST_I(rst), .VALID_I(c_valid), .READY_O(c_ready),
    .DATA_I(c_data), .MSB_FIRST_I(1'b1), .IDLE_LVL_I(1'b0), .ABORT_I(1'b0),
    .DO_O(c_do), .OE_O(c_oe), .BUSY_O(c_busy), .DONE_O(c_done), .ABRT_O(c_abrt),
    .DBG_STATE_O(c_dbg_state)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Entry per cycle: {ready, busy, oe, done, abrt, do}
  logic [5:0] exp_q[$];
  logic       abrt_model = 1'b0;

  // Push the expected cycles following an accept edge. ta>0 means ABORT_I is
  // sampled at accept-edge + ta.
  task automatic push_word(input logic [W-1:0] d, input logic m, input logic l, input int ta);
    int tend;
    int bi;
    logic b;
    tend = (ta > 0) ? ta + T : 2*T + W*D;
    for (int t = 0; t < tend; t++) begin
      if ((ta > 0 && t >= ta) || t < T || t >= T + W*D) begin
        b = l;
      end else begin
        bi = (t - T) / D;
        b  = m ? d[W-1-bi] : d[bi];
      end
      exp_q.push_back({1'b0, 1'b1, 1'b1, 1'b0, abrt_model, b});
    end
    exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b1, (ta > 0), l});
    abrt_model = (ta > 0);
  endtask

  // Monitor: compare one expected entry per cycle while any are queued
  always @(negedge clk) begin
    logic [5:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("cyc", {26'd0, ready, busy, oe, done, abrt, do_o}, {26'd0, e});
    end
  end

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", exp_q.size(), 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [W-1:0] d, input logic m, input logic l, input int ta);
    @(negedge clk);
    valid = 1'b1; data = d; msb = m; lvl = l;
    @(posedge clk); #1;
    valid = 1'b0;
    push_word(d, m, l, ta);
    data = W'($urandom_range(0, 255));
    msb  = 1'($urandom_range(0, 1));
    if (ta > 0) begin
      repeat (ta - 1) @(posedge clk);
      @(negedge clk);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
    end
    wait_drain();
  endtask

  task automatic send_b2b();
    @(negedge clk);
    valid = 1'b1; data = 8'hA5; msb = 1'b1; lvl = 1'b1;
    @(posedge clk); #1;
    push_word(8'hA5, 1'b1, 1'b1, 0);
    push_word(8'h5A, 1'b1, 1'b1, 0);
    data = 8'h5A;
    repeat (2*T + W*D + 1) @(posedge clk);
    #1;
    valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      data = W'($urandom_range(0, 255));
      @(posedge clk); #1;
    end
    wait_drain();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #1;
    chk("rst_do",    do_o,  0);
    chk("rst_oe",    oe,    0);
    chk("rst_ready", ready, 0);
    chk("rst_busy",  busy,  0);
    chk("rst_done",  done,  0);
    chk("rst_abrt",  abrt,  0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_pre_edge", ready, 0);
    @(posedge clk); #1;
    chk("ready_post_edge", ready, 1);
    chk("idle_oe", oe, 0);

    // DO follows the idle level with one clock of lag
    @(negedge clk); lvl = 1'b1;
    @(posedge clk); #1;
    chk("idle_do_hi", do_o, 1);
    @(negedge clk); lvl = 1'b0; #1;
    chk("idle_do_lag", do_o, 1);
    @(posedge clk); #1;
    chk("idle_do_lo", do_o, 0);

    send_word(8'h01, 1'b1, 1'b1, 0);
    send_word(8'h01, 1'b0, 1'b0, 0);
    send_b2b();
    send_word(8'hFF, 1'b1, 1'b0, 15);   // abort during bit 3
    send_word(8'h3C, 1'b0, 1'b1, 0);    // ABRT_O held until this DONE
    send_word(8'hAA, 1'b1, 1'b1, 1);    // abort in SETUP
    for (int i = 0; i < 3; i++) begin
      send_word(W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 0);
    end

    // Reset in the middle of SHIFT
    @(negedge clk);
    valid = 1'b1; data = 8'hC3; msb = 1'b1; lvl = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    chk("pre_rst_oe", oe, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_oe",    oe,    0);
    chk("mid_rst_do",    do_o,  0);
    chk("mid_rst_busy",  busy,  0);
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_done",  done,  0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    abrt_model = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", ready, 1);
    for (int i = 0; i < 4; i++) begin
      chk("post_rst_no_done", done, 0);
      @(posedge clk); #1;
    end
    send_word(8'h96, 1'b1, 1'b1, 0);

    // Corner instance: WIDTH=1, DIV=1, TURN_CYC=0
    @(negedge clk);
    c_valid = 1'b1; c_data = 1'b1;
    @(posedge clk); #1;
    c_valid = 1'b0;
    chk("c_oe_k",    c_oe,    1);
    chk("c_do_k",    c_do,    1);
    chk("c_busy_k",  c_busy,  1);
    chk("c_ready_k", c_ready, 0);
    @(posedge clk); #1;
    chk("c_oe_k1",    c_oe,    0);
    chk("c_done_k1",  c_done,  1);
    chk("c_abrt_k1",  c_abrt,  0);
    chk("c_ready_k1", c_ready, 1);
    @(posedge clk); #1;
    chk("c_done_k2", c_done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
